// File: rtl/aie2dma_framer.sv
// ---------------------------------------------------------------------------
// aie2dma_framer
//
// Takes the AIE output AXI-stream (IFFT symbols), buffers it in a small
// first-word-fall-through FIFO and re-emits it to the DMA S2MM channel with
// TLAST framing. Symbol and frame boundaries come from counting beats per
// symbol and symbols per frame. Capture is armed by a rising edge of the
// bf_stream window. If the window closes early, the frame is aborted, the
// buffered beats are flushed out, and a sticky error flag is set.
//
// Ports
//   clk, srstn        clock, synchronous active-low reset
//   bf_stream         frame window; a rising edge arms capture
//   aie_axi_*         AXI-stream input from the AIE (tvld/tdat in, trdy out)
//   dma_axi_*         AXI-stream output to DMA S2MM (tvld/tdat/tlast out, trdy in)
//   frame_done        one-cycle pulse when a complete frame has been delivered
//   symbol_cnt        symbols fully accepted in the current frame
//   short_frame_err   sticky; the window fell before the frame completed
//   busy              high whenever the framer is not idle
// ---------------------------------------------------------------------------
module aie2dma_framer #(
   parameter int DATA_WIDTH       = 64,
   parameter int DEPTH_OF_SYMBOL  = 13104,
   parameter int NUM_OF_SYMBOL    = 14,
   parameter int CNT_WIDTH        = 14,
   parameter int FIFO_DEPTH       = 32,
   parameter int TLAST_PER_SYMBOL = 1
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  bf_stream,
   input  logic                  aie_axi_tvld,
   input  logic [DATA_WIDTH-1:0] aie_axi_tdat,
   output logic                  aie_axi_trdy,
   output logic                  dma_axi_tvld,
   output logic [DATA_WIDTH-1:0] dma_axi_tdat,
   output logic                  dma_axi_tlast,
   input  logic                  dma_axi_trdy,
   output logic                  frame_done,
   output logic [7:0]            symbol_cnt,
   output logic                  short_frame_err,
   output logic                  busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_WIDTH + 1;

   localparam logic [CNT_WIDTH-1:0] LAST_SAMPLE = CNT_WIDTH'(DEPTH_OF_SYMBOL - 1);
   localparam logic [7:0]           LAST_SYMBOL = 8'(NUM_OF_SYMBOL - 1);
   localparam logic [CW-1:0]        READY_LIMIT = CW'(FIFO_DEPTH - 2);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      ABORT = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic                    bfPrev_q;
   logic                    trdy_q, trdy_d;
   logic [CNT_WIDTH-1:0]    sampleCnt_q, sampleCnt_d;
   logic [7:0]              symbolCnt_q, symbolCnt_d;
   logic                    shortErr_q, shortErr_d;
   logic                    frameDone_q, frameDone_d;

   logic [EW-1:0]           fifoMem_q [FIFO_DEPTH];
   logic [AW-1:0]           wrPtr_q, rdPtr_q;
   logic [CW-1:0]           fifoCount_q, fifoCount_d;

   logic                    outValid_q, outValid_d;
   logic [DATA_WIDTH-1:0]   outData_q, outData_d;
   logic                    outLast_q, outLast_d;

   logic                    push, pop, outFree;
   logic                    sampleLast, symbolLast, frameLastAccept, lastTag;
   logic                    bfRise, forceLast;
   logic [EW-1:0]           fifoHead;

   // Handshake and boundary decode shared by the FSM, counters and FIFO.
   always_comb begin
      push            = aie_axi_tvld & trdy_q;
      outFree         = ~outValid_q | dma_axi_trdy;
      pop             = (fifoCount_q != '0) & outFree;
      sampleLast      = (sampleCnt_q == LAST_SAMPLE);
      symbolLast      = (symbolCnt_q == LAST_SYMBOL);
      frameLastAccept = push & sampleLast & symbolLast;
      lastTag         = sampleLast & ((TLAST_PER_SYMBOL != 0) | symbolLast);
      bfRise          = bf_stream & ~bfPrev_q;
      fifoHead        = fifoMem_q[rdPtr_q];
   end

   // Next-state logic. A last beat accepted in the same cycle the window
   // falls still counts as a complete frame, so it is checked first.
   always_comb begin
      state_d     = state_q;
      shortErr_d  = shortErr_q;
      frameDone_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bfRise) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (frameLastAccept) begin
               state_d = DRAIN;
            end else if (!bf_stream) begin
               state_d    = ABORT;
               shortErr_d = 1'b1;
            end
         end
         DRAIN: begin
            if ((fifoCount_q == '0) && outFree) begin
               state_d     = DONE;
               frameDone_d = 1'b1;
            end
         end
         ABORT: begin
            if ((fifoCount_q == '0) && outFree) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sample/symbol counters; held at zero while idle so every frame starts clean.
   always_comb begin
      sampleCnt_d = sampleCnt_q;
      symbolCnt_d = symbolCnt_q;
      if (state_q == IDLE) begin
         sampleCnt_d = '0;
         symbolCnt_d = '0;
      end else if (push) begin
         if (sampleLast) begin
            sampleCnt_d = '0;
            symbolCnt_d = symbolCnt_q + 8'd1;
         end else begin
            sampleCnt_d = sampleCnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // FIFO occupancy, output stage and registered input ready.
   // Ready is computed from next-cycle state and occupancy, so it already
   // reflects the fill level the FIFO will have when the beat lands.
   // During an abort the beat that empties the FIFO closes the packet.
   always_comb begin
      case ({push, pop})
         2'b10:   fifoCount_d = fifoCount_q + CW'(1);
         2'b01:   fifoCount_d = fifoCount_q - CW'(1);
         default: fifoCount_d = fifoCount_q;
      endcase

      forceLast  = (state_d == ABORT) && (fifoCount_d == '0);

      outValid_d = outValid_q;
      outData_d  = outData_q;
      outLast_d  = outLast_q;
      if (pop) begin
         outValid_d = 1'b1;
         outData_d  = fifoHead[DATA_WIDTH-1:0];
         outLast_d  = fifoHead[DATA_WIDTH] | forceLast;
      end else if (dma_axi_trdy) begin
         outValid_d = 1'b0;
      end

      trdy_d = (state_d == RUN) && (fifoCount_d < READY_LIMIT);
   end

   // Control and datapath registers.
   always_ff @(posedge clk) begin
      if (!srstn) begin
         state_q     <= IDLE;
         bfPrev_q    <= 1'b0;
         trdy_q      <= 1'b0;
         sampleCnt_q <= '0;
         symbolCnt_q <= '0;
         shortErr_q  <= 1'b0;
         frameDone_q <= 1'b0;
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         fifoCount_q <= '0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outLast_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bfPrev_q    <= bf_stream;
         trdy_q      <= trdy_d;
         sampleCnt_q <= sampleCnt_d;
         symbolCnt_q <= symbolCnt_d;
         shortErr_q  <= shortErr_d;
         frameDone_q <= frameDone_d;
         fifoCount_q <= fifoCount_d;
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         outLast_q   <= outLast_d;
         if (push) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
      end
   end

   // FIFO storage needs no reset; the pointers alone define its contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= {lastTag, aie_axi_tdat};
      end
   end

   assign aie_axi_trdy    = trdy_q;
   assign dma_axi_tvld    = outValid_q;
   assign dma_axi_tdat    = outData_q;
   assign dma_axi_tlast   = outLast_q;
   assign frame_done      = frameDone_q;
   assign symbol_cnt      = symbolCnt_q;
   assign short_frame_err = shortErr_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_aie2dma_framer.sv
// ---------------------------------------------------------------------------
// tb_aie2dma_framer
//
// Two framer instances share every input: dutA tags TLAST per symbol, dutB
// only at the end of the frame. A negedge monitor records every output beat
// of both instances; each test task builds its expected stream from beat
// indices and frame geometry and compares it with what was recorded.
// ---------------------------------------------------------------------------
module tb_aie2dma_framer;

   localparam int DW    = 64;
   localparam int DEPTH = 8;
   localparam int NSYM  = 3;
   localparam int FRAME = DEPTH * NSYM;
   localparam int FD    = 16;

   logic          clk;
   logic          srstn;
   logic          bf_stream;
   logic          aie_tvld;
   logic [DW-1:0] aie_tdat;
   logic          dma_trdy;

   logic          trdyA, tvldA, tlastA, doneA, errA, busyA;
   logic [DW-1:0] tdatA;
   logic [7:0]    symA;
   logic          trdyB, tvldB, tlastB, doneB, errB, busyB;
   logic [DW-1:0] tdatB;
   logic [7:0]    symB;

   int nChecks = 0;
   int nFails  = 0;

   int            dmaMode = 0;
   logic [DW-1:0] txData[$];
   logic [DW:0]   obsA[$];
   logic [DW:0]   obsB[$];
   int            cyc = 0;
   int            accCount, firstAccCyc, firstOutCyc, lastHsCycA;
   int            doneCountA, doneCountB, doneCycA;
   logic [7:0]    doneSymA;

   aie2dma_framer #(
      .DATA_WIDTH(DW), .DEPTH_OF_SYMBOL(DEPTH), .NUM_OF_SYMBOL(NSYM),
      .CNT_WIDTH(3), .FIFO_DEPTH(FD), .TLAST_PER_SYMBOL(1)
   ) dutA (
      .clk(clk), .srstn(srstn), .bf_stream(bf_stream),
      .aie_axi_tvld(aie_tvld), .aie_axi_tdat(aie_tdat), .aie_axi_trdy(trdyA),
      .dma_axi_tvld(tvldA), .dma_axi_tdat(tdatA), .dma_axi_tlast(tlastA),
      .dma_axi_trdy(dma_trdy), .frame_done(doneA), .symbol_cnt(symA),
      .short_frame_err(errA), .busy(busyA)
   );

   aie2dma_framer #(
      .DATA_WIDTH(DW), .DEPTH_OF_SYMBOL(DEPTH), .NUM_OF_SYMBOL(NSYM),
      .CNT_WIDTH(3), .FIFO_DEPTH(FD), .TLAST_PER_SYMBOL(0)
   ) dutB (
      .clk(clk), .srstn(srstn), .bf_stream(bf_stream),
      .aie_axi_tvld(aie_tvld), .aie_axi_tdat(aie_tdat), .aie_axi_trdy(trdyB),
      .dma_axi_tvld(tvldB), .dma_axi_tdat(tdatB), .dma_axi_tlast(tlastB),
      .dma_axi_trdy(dma_trdy), .frame_done(doneB), .symbol_cnt(symB),
      .short_frame_err(errB), .busy(busyB)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DMA ready pattern: 0 = always ready, 1 = random, other = stalled
   initial begin
      dma_trdy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (dmaMode)
            0:       dma_trdy = 1'b1;
            1:       dma_trdy = ($urandom_range(0, 3) != 0);
            default: dma_trdy = 1'b0;
         endcase
      end
   end

   // Records handshakes on both sides, once per cycle, away from the clock edge
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (aie_tvld && trdyA) begin
            accCount++;
            if (firstAccCyc < 0) firstAccCyc = cyc;
         end
         if (tvldA && firstOutCyc < 0) firstOutCyc = cyc;
         if (tvldA && dma_trdy) begin
            obsA.push_back({tlastA, tdatA});
            lastHsCycA = cyc;
         end
         if (tvldB && dma_trdy) obsB.push_back({tlastB, tdatB});
         if (doneA) begin
            doneCountA++;
            doneCycA = cyc;
            doneSymA = symA;
         end
         if (doneB) doneCountB++;
      end
   end

   // Global time limit so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected TLAST for beat k of an n-beat frame
   function automatic logic modelLast(int k, int n, bit perSymbol, bit aborted);
      if (aborted && k == n - 1) return 1'b1;
      if (perSymbol) return (k % DEPTH) == DEPTH - 1;
      return k == FRAME - 1;
   endfunction

   task automatic clearObs();
      obsA.delete();
      obsB.delete();
      accCount    = 0;
      firstAccCyc = -1;
      firstOutCyc = -1;
      lastHsCycA  = -1;
      doneCountA  = 0;
      doneCountB  = 0;
      doneCycA    = -1;
      doneSymA    = '0;
   endtask

   task automatic fillData(input int n, input bit ramp);
      txData.delete();
      for (int k = 0; k < n; k++) begin
         if (ramp) txData.push_back(DW'(k));
         else      txData.push_back({$urandom, $urandom});
      end
   endtask

   task automatic startFrame();
      @(posedge clk);
      #1;
      bf_stream = 1'b0;
      @(posedge clk);
      #1;
      bf_stream = 1'b1;
   endtask

   // Offers txData[0..n-1] with the given valid density (percent)
   task automatic applyStimulus(input int n, input int density, output bit ok);
      int idx   = 0;
      int guard = 0;
      while (idx < n && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
         aie_tvld = ($urandom_range(1, 100) <= density);
         aie_tdat = aie_tvld ? txData[idx] : {$urandom, $urandom};
         @(negedge clk);
         if (aie_tvld && trdyA) idx++;
      end
      @(posedge clk);
      #1;
      aie_tvld = 1'b0;
      ok = (idx == n);
   endtask

   // Waits for n beats on both outputs and for the framer to go idle
   task automatic waitDrain(input int n, output bit ok);
      int g = 0;
      do begin
         @(negedge clk);
         #1;
         g++;
      end while (!(obsA.size() >= n && obsB.size() >= n && busyA === 1'b0) && g < 3000);
      ok = (g < 3000);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      srstn = 1'b0; bf_stream = 1'b0; aie_tvld = 1'b0; aie_tdat = '0; dmaMode = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      nChecks += 6;
      if ({trdyA, tvldA, tlastA, doneA, errA, busyA} !== 6'b0) begin
         nFails++; $display("[TB] FAIL reset_ctrlA: got %b want 000000", {trdyA, tvldA, tlastA, doneA, errA, busyA});
      end
      if (tdatA !== '0) begin nFails++; $display("[TB] FAIL reset_tdatA: got %h want 0", tdatA); end
      if (symA !== 8'd0) begin nFails++; $display("[TB] FAIL reset_symA: got %0d want 0", symA); end
      if ({trdyB, tvldB, tlastB, doneB, errB, busyB} !== 6'b0) begin
         nFails++; $display("[TB] FAIL reset_ctrlB: got %b want 000000", {trdyB, tvldB, tlastB, doneB, errB, busyB});
      end
      if (tdatB !== '0) begin nFails++; $display("[TB] FAIL reset_tdatB: got %h want 0", tdatB); end
      if (symB !== 8'd0) begin nFails++; $display("[TB] FAIL reset_symB: got %0d want 0", symB); end
      @(posedge clk);
      #1;
      srstn = 1'b1;
   endtask

   task automatic test_idle_offer();
      int trdyHigh = 0;
      clearObs();
      bf_stream = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         aie_tvld = 1'b1;
         aie_tdat = {$urandom, $urandom};
         @(negedge clk);
         if (trdyA !== 1'b0) trdyHigh++;
      end
      @(posedge clk);
      #1;
      aie_tvld = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      nChecks += 4;
      if (trdyHigh != 0) begin nFails++; $display("[TB] FAIL idle_trdy: got %0d ready cycles want 0", trdyHigh); end
      if (obsA.size() != 0) begin nFails++; $display("[TB] FAIL idle_emit: got %0d beats want 0", obsA.size()); end
      if (errA !== 1'b0) begin nFails++; $display("[TB] FAIL idle_err: got %b want 0", errA); end
      if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL idle_busy: got %b want 0", busyA); end
   endtask

   task automatic test_single_frame();
      bit ok1, ok2;
      logic [DW:0] gotA, gotB, expA, expB;
      clearObs();
      fillData(FRAME, 1'b1);
      dmaMode = 0;
      startFrame();
      applyStimulus(FRAME, 100, ok1);
      waitDrain(FRAME, ok2);
      bf_stream = 1'b0;
      nChecks += 2;
      if (!ok1) begin nFails++; $display("[TB] FAIL frame_input_timeout: got stalled want %0d beats", FRAME); end
      if (!ok2) begin nFails++; $display("[TB] FAIL frame_output_timeout: got %0d beats want %0d", obsA.size(), FRAME); end
      for (int k = 0; k < FRAME; k++) begin
         expA = {modelLast(k, FRAME, 1'b1, 1'b0), txData[k]};
         expB = {modelLast(k, FRAME, 1'b0, 1'b0), txData[k]};
         gotA = (k < obsA.size()) ? obsA[k] : 'x;
         gotB = (k < obsB.size()) ? obsB[k] : 'x;
         nChecks += 2;
         if (gotA !== expA) begin nFails++; $display("[TB] FAIL frame_beatA[%0d]: got %h want %h", k, gotA, expA); end
         if (gotB !== expB) begin nFails++; $display("[TB] FAIL frame_beatB[%0d]: got %h want %h", k, gotB, expB); end
      end
      nChecks += 6;
      if (obsA.size() != FRAME) begin nFails++; $display("[TB] FAIL frame_countA: got %0d want %0d", obsA.size(), FRAME); end
      if (doneCountA != 1 || doneCountB != 1) begin
         nFails++; $display("[TB] FAIL frame_done_count: got %0d/%0d want 1/1", doneCountA, doneCountB);
      end
      if (doneCycA != lastHsCycA + 1) begin
         nFails++; $display("[TB] FAIL frame_done_timing: got cycle %0d want %0d", doneCycA, lastHsCycA + 1);
      end
      if (doneSymA !== 8'(NSYM)) begin nFails++; $display("[TB] FAIL frame_symbol_cnt: got %0d want %0d", doneSymA, NSYM); end
      if (firstOutCyc - firstAccCyc != 2) begin
         nFails++; $display("[TB] FAIL frame_latency: got %0d want 2", firstOutCyc - firstAccCyc);
      end
      if (errA !== 1'b0) begin nFails++; $display("[TB] FAIL frame_err: got %b want 0", errA); end
   endtask

   task automatic test_backpressure();
      bit ok1, ok2;
      logic [DW:0] gotA, gotB, expA, expB;
      clearObs();
      fillData(FRAME, 1'b0);
      dmaMode = 2;
      startFrame();
      fork
         applyStimulus(FRAME, 100, ok1);
         begin
            repeat (40) @(negedge clk);
            #1;
            nChecks += 2;
            if (accCount != FD - 1) begin
               nFails++; $display("[TB] FAIL bp_accepted: got %0d want %0d", accCount, FD - 1);
            end
            if (trdyA !== 1'b0) begin nFails++; $display("[TB] FAIL bp_trdy: got %b want 0", trdyA); end
            dmaMode = 1;
         end
      join
      waitDrain(FRAME, ok2);
      bf_stream = 1'b0;
      nChecks += 4;
      if (!ok1 || !ok2) begin nFails++; $display("[TB] FAIL bp_timeout: got %b%b want 11", ok1, ok2); end
      if (obsA.size() != FRAME || obsB.size() != FRAME) begin
         nFails++; $display("[TB] FAIL bp_count: got %0d/%0d want %0d", obsA.size(), obsB.size(), FRAME);
      end
      if (doneCountA != 1) begin nFails++; $display("[TB] FAIL bp_done: got %0d want 1", doneCountA); end
      if (doneSymA !== 8'(NSYM)) begin nFails++; $display("[TB] FAIL bp_symbol_cnt: got %0d want %0d", doneSymA, NSYM); end
      for (int k = 0; k < FRAME; k++) begin
         expA = {modelLast(k, FRAME, 1'b1, 1'b0), txData[k]};
         expB = {modelLast(k, FRAME, 1'b0, 1'b0), txData[k]};
         gotA = (k < obsA.size()) ? obsA[k] : 'x;
         gotB = (k < obsB.size()) ? obsB[k] : 'x;
         nChecks += 2;
         if (gotA !== expA) begin nFails++; $display("[TB] FAIL bp_beatA[%0d]: got %h want %h", k, gotA, expA); end
         if (gotB !== expB) begin nFails++; $display("[TB] FAIL bp_beatB[%0d]: got %h want %h", k, gotB, expB); end
      end
   endtask

   task automatic test_abort();
      bit ok1, ok2;
      int n = 10;
      logic [DW:0] gotA, gotB, expA, expB;
      clearObs();
      fillData(n, 1'b0);
      dmaMode = 2;
      startFrame();
      applyStimulus(n, 70, ok1);
      bf_stream = 1'b0;
      dmaMode   = 1;
      waitDrain(n, ok2);
      nChecks += 6;
      if (!ok1 || !ok2) begin nFails++; $display("[TB] FAIL abort_timeout: got %b%b want 11", ok1, ok2); end
      if (obsA.size() != n) begin nFails++; $display("[TB] FAIL abort_count: got %0d want %0d", obsA.size(), n); end
      if (errA !== 1'b1 || errB !== 1'b1) begin nFails++; $display("[TB] FAIL abort_err: got %b%b want 11", errA, errB); end
      if (doneCountA != 0 || doneCountB != 0) begin
         nFails++; $display("[TB] FAIL abort_done: got %0d/%0d want 0/0", doneCountA, doneCountB);
      end
      if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL abort_busy: got %b want 0", busyA); end
      if (trdyA !== 1'b0) begin nFails++; $display("[TB] FAIL abort_trdy: got %b want 0", trdyA); end
      for (int k = 0; k < n; k++) begin
         expA = {modelLast(k, n, 1'b1, 1'b1), txData[k]};
         expB = {modelLast(k, n, 1'b0, 1'b1), txData[k]};
         gotA = (k < obsA.size()) ? obsA[k] : 'x;
         gotB = (k < obsB.size()) ? obsB[k] : 'x;
         nChecks += 2;
         if (gotA !== expA) begin nFails++; $display("[TB] FAIL abort_beatA[%0d]: got %h want %h", k, gotA, expA); end
         if (gotB !== expB) begin nFails++; $display("[TB] FAIL abort_beatB[%0d]: got %h want %h", k, gotB, expB); end
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok1, ok2;
      logic [DW:0] gotA, expA;
      clearObs();
      fillData(5, 1'b0);
      dmaMode = 2;
      startFrame();
      applyStimulus(5, 100, ok1);
      srstn     = 1'b0;
      bf_stream = 1'b0;
      @(posedge clk);
      #1;
      srstn = 1'b1;
      @(negedge clk);
      nChecks += 4;
      if (!ok1) begin nFails++; $display("[TB] FAIL rst_input_timeout: got stalled want 5 beats"); end
      if ({trdyA, tvldA, tlastA, doneA, errA, busyA} !== 6'b0) begin
         nFails++; $display("[TB] FAIL rst_ctrl: got %b want 000000", {trdyA, tvldA, tlastA, doneA, errA, busyA});
      end
      if (tdatA !== '0) begin nFails++; $display("[TB] FAIL rst_tdat: got %h want 0", tdatA); end
      if (symA !== 8'd0) begin nFails++; $display("[TB] FAIL rst_sym: got %0d want 0", symA); end

      clearObs();
      fillData(FRAME, 1'b1);
      dmaMode = 1;
      startFrame();
      applyStimulus(FRAME, 90, ok1);
      waitDrain(FRAME, ok2);
      bf_stream = 1'b0;
      nChecks += 3;
      if (!ok1 || !ok2) begin nFails++; $display("[TB] FAIL rst_next_timeout: got %b%b want 11", ok1, ok2); end
      if (obsA.size() != FRAME) begin nFails++; $display("[TB] FAIL rst_next_count: got %0d want %0d", obsA.size(), FRAME); end
      if (doneCountA != 1) begin nFails++; $display("[TB] FAIL rst_next_done: got %0d want 1", doneCountA); end
      for (int k = 0; k < FRAME; k++) begin
         expA = {modelLast(k, FRAME, 1'b1, 1'b0), txData[k]};
         gotA = (k < obsA.size()) ? obsA[k] : 'x;
         nChecks++;
         if (gotA !== expA) begin nFails++; $display("[TB] FAIL rst_next_beat[%0d]: got %h want %h", k, gotA, expA); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      logic [DW:0] gotA, gotB, expA, expB;
      for (int f = 0; f < 3; f++) begin
         clearObs();
         fillData(FRAME, 1'b0);
         dmaMode = 1;
         startFrame();
         applyStimulus(FRAME, $urandom_range(50, 100), ok1);
         waitDrain(FRAME, ok2);
         nChecks += 4;
         if (!ok1 || !ok2) begin nFails++; $display("[TB] FAIL b2b%0d_timeout: got %b%b want 11", f, ok1, ok2); end
         if (doneCountA != 1 || doneCountB != 1) begin
            nFails++; $display("[TB] FAIL b2b%0d_done: got %0d/%0d want 1/1", f, doneCountA, doneCountB);
         end
         if (doneSymA !== 8'(NSYM)) begin nFails++; $display("[TB] FAIL b2b%0d_symbol_cnt: got %0d want %0d", f, doneSymA, NSYM); end
         if (errA !== 1'b0) begin nFails++; $display("[TB] FAIL b2b%0d_err: got %b want 0", f, errA); end
         for (int k = 0; k < FRAME; k++) begin
            expA = {modelLast(k, FRAME, 1'b1, 1'b0), txData[k]};
            expB = {modelLast(k, FRAME, 1'b0, 1'b0), txData[k]};
            gotA = (k < obsA.size()) ? obsA[k] : 'x;
            gotB = (k < obsB.size()) ? obsB[k] : 'x;
            nChecks += 2;
            if (gotA !== expA) begin nFails++; $display("[TB] FAIL b2b%0d_beatA[%0d]: got %h want %h", f, k, gotA, expA); end
            if (gotB !== expB) begin nFails++; $display("[TB] FAIL b2b%0d_beatB[%0d]: got %h want %h", f, k, gotB, expB); end
         end
      end
      bf_stream = 1'b0;
   endtask

   initial begin
      clearObs();
      test_reset();
      test_idle_offer();
      test_single_frame();
      test_backpressure();
      test_abort();
      test_reset_mid_frame();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
